// File: rtl/klein_finish_if.sv
// Handshake bundle for klein_finish: six input words with valid/ready in, one result with valid/ready out.
interface klein_finish_if #(
    parameter int BIT_WIDTH_I = 8
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [BIT_WIDTH_I-1:0] sum_a_i;
    logic [BIT_WIDTH_I-1:0] cs_a_i;
    logic [BIT_WIDTH_I-1:0] ccs_a_i;
    logic [BIT_WIDTH_I-1:0] sum_b_i;
    logic [BIT_WIDTH_I-1:0] cs_b_i;
    logic [BIT_WIDTH_I-1:0] ccs_b_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [BIT_WIDTH_I-1:0] sum_o;

    modport master (
        output in_valid_i, sum_a_i, cs_a_i, ccs_a_i, sum_b_i, cs_b_i, ccs_b_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o
    );

    modport slave (
        input  in_valid_i, sum_a_i, cs_a_i, ccs_a_i, sum_b_i, cs_b_i, ccs_b_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o
    );
endinterface

// File: rtl/klein_finish.sv
// Final Kahan-Babuska-Klein stage: folds two (sum, cs, ccs) lanes into one minifloat through a shared adder.
// Define KLEIN_FINISH_FTZ_EN to flush subnormal adder inputs and results to signed zero.
module klein_finish #(
    parameter int EXP_WIDTH_I  = 5,
    parameter int MANT_WIDTH_I = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    klein_finish_if.slave bus
);
    localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I;
    localparam int E    = EXP_WIDTH_I;
    localparam int M    = MANT_WIDTH_I;
    localparam int SW   = M + 4;
    localparam int EMAX = (1 << E) - 1;
    localparam logic [BIT_WIDTH_I-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4, DONE} state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [BIT_WIDTH_I-1:0] r_sumA, r_csA, r_ccsA, r_sumB, r_csB, r_ccsB;
    logic [BIT_WIDTH_I-1:0] r_t0, r_t1, r_t2, r_t3, r_sum;
    logic [BIT_WIDTH_I-1:0] w_opA, w_opB, w_addRes;

    // Operands are aligned with three extra bits (guard, round, sticky) so rounding sees the exact sum.
    function automatic logic [BIT_WIDTH_I-1:0] fpAdd(input logic [BIT_WIDTH_I-1:0] a,
                                                     input logic [BIT_WIDTH_I-1:0] b);
        logic                   sA, sB, sBig, nanA, nanB, infA, infB, sticky, up, implicitBit;
        logic [E-1:0]           eA, eB;
        logic [M-1:0]           mA, mB, mOut;
        logic [SW-1:0]          bigExt, smallExt, smallSh;
        logic [SW:0]            sumV, norm;
        logic [M:0]             kept;
        logic [M+1:0]           rounded;
        logic [BIT_WIDTH_I-1:0] res;
        int                     effA, effB, effBig, diff, sh, p, lz, lim, e;
        sA = a[BIT_WIDTH_I-1];
        sB = b[BIT_WIDTH_I-1];
        eA = a[BIT_WIDTH_I-2:M];
        eB = b[BIT_WIDTH_I-2:M];
        mA = a[M-1:0];
        mB = b[M-1:0];
`ifdef KLEIN_FINISH_FTZ_EN
        if (eA == '0) mA = '0;
        if (eB == '0) mB = '0;
`endif
        nanA = (eA == '1) && (mA != '0);
        nanB = (eB == '1) && (mB != '0);
        infA = (eA == '1) && (mA == '0);
        infB = (eB == '1) && (mB == '0);
        res  = '0;
        if (nanA || nanB || (infA && infB && (sA != sB))) begin
            res = QNAN;
        end else if (infA) begin
            res = a;
        end else if (infB) begin
            res = b;
        end else begin
            effA = (eA == '0) ? 1 : int'(eA);
            effB = (eB == '0) ? 1 : int'(eB);
            if ({eB, mB} > {eA, mA}) begin
                bigExt   = {eB != '0, mB, 3'b000};
                smallExt = {eA != '0, mA, 3'b000};
                effBig   = effB;
                diff     = effB - effA;
                sBig     = sB;
            end else begin
                bigExt   = {eA != '0, mA, 3'b000};
                smallExt = {eB != '0, mB, 3'b000};
                effBig   = effA;
                diff     = effA - effB;
                sBig     = sA;
            end
            sh      = (diff > SW) ? SW : diff;
            smallSh = smallExt >> sh;
            sticky  = ((smallSh << sh) != smallExt);
            smallSh = smallSh | SW'(sticky);
            if (sA == sB) sumV = {1'b0, bigExt} + {1'b0, smallSh};
            else          sumV = {1'b0, bigExt} - {1'b0, smallSh};
            if (sumV == '0) begin
                res = {sA & sB, {(BIT_WIDTH_I-1){1'b0}}};
            end else begin
                e = effBig;
                if (sumV[SW]) begin
                    norm = (sumV >> 1) | {{SW{1'b0}}, sumV[0]};
                    e    = e + 1;
                end else begin
                    // Left shift stops at the minimum exponent, leaving a subnormal.
                    p = 0;
                    for (int i = 0; i < SW; i++) begin
                        if (sumV[i]) p = i;
                    end
                    lz   = SW - 1 - p;
                    lim  = e - 1;
                    sh   = (lz < lim) ? lz : lim;
                    norm = sumV << sh;
                    e    = e - sh;
                end
                kept    = norm[SW-1:3];
                up      = norm[2] & (norm[1] | norm[0] | kept[0]);
                rounded = {1'b0, kept} + {{(M+1){1'b0}}, up};
                if (rounded[M+1]) begin
                    e           = e + 1;
                    implicitBit = 1'b1;
                    mOut        = '0;
                end else begin
                    implicitBit = rounded[M];
                    mOut        = rounded[M-1:0];
                end
                if (e >= EMAX) begin
                    res = {sBig, {E{1'b1}}, {M{1'b0}}};
                end else if (!implicitBit) begin
`ifdef KLEIN_FINISH_FTZ_EN
                    res = {sBig, {(BIT_WIDTH_I-1){1'b0}}};
`else
                    res = {sBig, {E{1'b0}}, mOut};
`endif
                end else begin
                    res = {sBig, E'(e), mOut};
                end
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid_i) w_nextState = S0;
            S0:      w_nextState = S1;
            S1:      w_nextState = S2;
            S2:      w_nextState = S3;
            S3:      w_nextState = S4;
            S4:      w_nextState = DONE;
            DONE:    if (bus.out_ready_i) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Small compensation terms are combined before the large running sums.
    always_comb begin
        w_opA = '0;
        w_opB = '0;
        case (r_state)
            S0: begin w_opA = r_ccsA; w_opB = r_ccsB; end
            S1: begin w_opA = r_csA;  w_opB = r_csB;  end
            S2: begin w_opA = r_t1;   w_opB = r_t0;   end
            S3: begin w_opA = r_sumA; w_opB = r_sumB; end
            S4: begin w_opA = r_t3;   w_opB = r_t2;   end
            default: ;
        endcase
    end

    assign w_addRes = fpAdd(w_opA, w_opB);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sumA <= '0; r_csA <= '0; r_ccsA <= '0;
            r_sumB <= '0; r_csB <= '0; r_ccsB <= '0;
            r_t0   <= '0; r_t1  <= '0; r_t2   <= '0; r_t3 <= '0;
            r_sum  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid_i) begin
                    r_sumA <= bus.sum_a_i; r_csA <= bus.cs_a_i; r_ccsA <= bus.ccs_a_i;
                    r_sumB <= bus.sum_b_i; r_csB <= bus.cs_b_i; r_ccsB <= bus.ccs_b_i;
                end
                S0:      r_t0  <= w_addRes;
                S1:      r_t1  <= w_addRes;
                S2:      r_t2  <= w_addRes;
                S3:      r_t3  <= w_addRes;
                S4:      r_sum <= w_addRes;
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == IDLE);
    assign bus.out_valid_o = (r_state == DONE);
    assign bus.sum_o       = r_sum;
endmodule

// File: tb/tb_klein_finish.sv
// Bench for klein_finish (E5M2): directed cases plus random triples against a real-valued reference.
module tb_klein_finish;
    logic clk = 1'b0;
    logic rstN;
    int   cycleCnt = 0;
    int   testCount = 0;
    int   failCount = 0;
    int   acceptCnt = 0;
    logic [7:0] expSum;

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    klein_finish_if #(.BIT_WIDTH_I(8)) bus ();
    klein_finish #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2)) dut (.clk_i(clk), .rst_ni(rstN), .bus(bus));

    function automatic real pow2(int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real codeMag(logic [7:0] c);
        int ex = int'(c[6:2]);
        int mn = int'(c[1:0]);
        if (ex == 0) return mn * pow2(-16);
        return (4 + mn) * pow2(ex - 17);
    endfunction

    // Exact real sum, then the nearest E5M2 code (ties to even code; 0x7C stands in for overflow).
    function automatic logic [7:0] refAdd(logic [7:0] a, logic [7:0] b);
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic [7:0] best;
        logic [7:0] res;
        real vx, vy, s, mag, d, bestD;
`ifdef KLEIN_FINISH_FTZ_EN
        if (x[6:2] == 5'd0) x = {x[7], 7'd0};
        if (y[6:2] == 5'd0) y = {y[7], 7'd0};
`endif
        if ((x[6:2] == 5'h1F && x[1:0] != 2'd0) || (y[6:2] == 5'h1F && y[1:0] != 2'd0)) return 8'h7E;
        if (x[6:0] == 7'h7C && y[6:0] == 7'h7C) return (x[7] != y[7]) ? 8'h7E : x;
        if (x[6:0] == 7'h7C) return x;
        if (y[6:0] == 7'h7C) return y;
        vx = x[7] ? -codeMag(x) : codeMag(x);
        vy = y[7] ? -codeMag(y) : codeMag(y);
        if (vx == 0.0 && vy == 0.0) return {x[7] & y[7], 7'd0};
        s = vx + vy;
        if (s == 0.0) return 8'h00;
        mag   = (s < 0.0) ? -s : s;
        best  = 8'h00;
        bestD = 1.0e30;
        for (int c = 0; c <= 124; c++) begin
            d = mag - codeMag(8'(c));
            if (d < 0.0) d = -d;
            if (d < bestD || (d == bestD && (c % 2) == 0)) begin
                bestD = d;
                best  = 8'(c);
            end
        end
        res = {s < 0.0, best[6:0]};
`ifdef KLEIN_FINISH_FTZ_EN
        if (best[6:2] == 5'd0) res = {res[7], 7'd0};
`endif
        return res;
    endfunction

    function automatic logic [7:0] refKlein(logic [7:0] sa, csa, ccsa, sb, csb, ccsb);
        return refAdd(refAdd(sa, sb), refAdd(refAdd(csa, csb), refAdd(ccsa, ccsb)));
    endfunction

    function automatic logic [7:0] randCode();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return {1'($urandom), 5'($urandom_range(0, 30)), 2'($urandom)};
    endfunction

    task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(logic [7:0] sa, csa, ccsa, sb, csb, ccsb);
        @(negedge clk);
        bus.sum_a_i = sa; bus.cs_a_i = csa; bus.ccs_a_i = ccsa;
        bus.sum_b_i = sb; bus.cs_b_i = csb; bus.ccs_b_i = ccsb;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 20 && bus.in_ready_o !== 1'b1; i++) @(negedge clk);
        checkValue("inReadyAtAccept", 32'(bus.in_ready_o), 32'd1);
        acceptCnt = cycleCnt;
        expSum = refKlein(sa, csa, ccsa, sb, csb, ccsb);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.sum_a_i = 8'($urandom); bus.cs_a_i = 8'($urandom); bus.ccs_a_i = 8'($urandom);
        bus.sum_b_i = 8'($urandom); bus.cs_b_i = 8'($urandom); bus.ccs_b_i = 8'($urandom);
    endtask

    task automatic checkOutput(string tag, logic [7:0] exp, int holdCycles);
        int waited = 0;
        @(negedge clk);
        while (bus.out_valid_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkValue({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        if (bus.out_valid_o !== 1'b1) return;
        checkValue({tag, "_latency"}, 32'(cycleCnt - acceptCnt), 32'd6);
        checkValue({tag, "_sum"}, 32'(bus.sum_o), 32'(exp));
        checkValue({tag, "_busy"}, 32'(bus.in_ready_o), 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkValue({tag, "_holdSum"}, 32'(bus.sum_o), 32'(exp));
            checkValue({tag, "_holdValid"}, 32'(bus.out_valid_o), 32'd1);
            checkValue({tag, "_holdBusy"}, 32'(bus.in_ready_o), 32'd0);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        checkValue({tag, "_validDrop"}, 32'(bus.out_valid_o), 32'd0);
        checkValue({tag, "_readyBack"}, 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] v [6];
        rstN = 1'b0;
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.sum_a_i = '0; bus.cs_a_i = '0; bus.ccs_a_i = '0;
        bus.sum_b_i = '0; bus.cs_b_i = '0; bus.ccs_b_i = '0;
        #2;
        checkValue("resetInReady", 32'(bus.in_ready_o), 32'd1);
        checkValue("resetOutValid", 32'(bus.out_valid_o), 32'd0);
        checkValue("resetSum", 32'(bus.sum_o), 32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        applyStimulus(8'h3C, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
        checkOutput("basicAdd", 8'h40, 0);
        applyStimulus(8'h40, 8'h38, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("compensation", 8'h41, 0);
        applyStimulus(8'h7C, 8'h00, 8'h00, 8'hFC, 8'h00, 8'h00);
        checkOutput("infMinusInf", 8'h7E, 0);
        applyStimulus(8'h7B, 8'h00, 8'h00, 8'h7B, 8'h00, 8'h00);
        checkOutput("overflow", 8'h7C, 0);
        applyStimulus(8'h3C, 8'h00, 8'h00, 8'hBC, 8'h00, 8'h00);
        checkOutput("cancelToZero", 8'h00, 0);
        applyStimulus(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        checkOutput("negZero", 8'h80, 0);
        applyStimulus(8'h3C, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
        checkOutput("backpressure", 8'h40, 10);

        applyStimulus(8'h3C, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkValue("midResetOutValid", 32'(bus.out_valid_o), 32'd0);
        checkValue("midResetInReady", 32'(bus.in_ready_o), 32'd1);
        checkValue("midResetSum", 32'(bus.sum_o), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(8'h3C, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
        checkOutput("afterReset", 8'h40, 0);

        applyStimulus(8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
`ifdef KLEIN_FINISH_FTZ_EN
        checkOutput("subnormal", 8'h00, 0);
`else
        checkOutput("subnormal", 8'h02, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 6; k++) v[k] = randCode();
            applyStimulus(v[0], v[1], v[2], v[3], v[4], v[5]);
            checkOutput("random", expSum, (n % 5 == 0) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
